// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU op encoding and the decoded control bundle
// used by the decode/execute slice and its ALU.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_write;
    logic    alu_src;
    logic    is_branch;
    logic    is_jump;
    logic    zext;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_execute_if.sv
// Bus between the IFU/register file (master) and the decode/execute slice (slave).
// There is no valid/ready handshake: the slave accepts instruction, data_a and data_b
// on every rising edge, and data_a/data_b must be the register-file reads of addr_a/addr_b.
interface mips_decode_execute_if;
  import mips_pkg::*;

  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic [4:0]      addr_a;
  logic [4:0]      addr_b;
  logic [4:0]      addr_in;
  logic            reg_write;
  logic            mem_write;
  logic            is_branch;
  logic            is_jump;
  logic [15:0]     imm16;
  logic [25:0]     addr26;
  logic [XLEN-1:0] alu_out;
  logic            alu_zout;

  modport master (
    output instruction, data_a, data_b,
    input  addr_a, addr_b, addr_in, reg_write, mem_write, is_branch, is_jump,
           imm16, addr26, alu_out, alu_zout
  );

  modport slave (
    input  instruction, data_a, data_b,
    output addr_a, addr_b, addr_in, reg_write, mem_write, is_branch, is_jump,
           imm16, addr26, alu_out, alu_zout
  );

endinterface

// File: rtl/mips_alu.sv
// Pure combinational 32-bit ALU; shifts operate on in2 (rt) by shamt.
module mips_alu
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  alu_op_t         op,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      ALU_XOR: result = in1 ^ in2;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLL: result = in2 << shamt;
      ALU_SRL: result = in2 >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode + execute: combinational decode and ALU, with all
// decoded controls and the ALU result captured in one output register stage.
module mips_decode_execute
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_decode_execute_if.slave bus
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [15:0]      imm;
  ctrl_t            ctrl;
  logic [4:0]       dest;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  assign opcode = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];
  assign imm    = bus.instruction[15:0];

  // Register read addresses bypass the output stage so the register file can
  // return data_a/data_b in the same cycle.
  assign bus.addr_a = bus.instruction[25:21];
  assign bus.addr_b = bus.instruction[20:16];

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        case (funct)
          F_ADD, F_ADDU: ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU: ctrl.alu_op = ALU_SUB;
          F_AND:         ctrl.alu_op = ALU_AND;
          F_OR:          ctrl.alu_op = ALU_OR;
          F_XOR:         ctrl.alu_op = ALU_XOR;
          F_SLT:         ctrl.alu_op = ALU_SLT;
          F_SLL:         ctrl.alu_op = ALU_SLL;
          F_SRL:         ctrl.alu_op = ALU_SRL;
          default:       ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zext      = 1'b1;
        ctrl.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zext      = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zext      = 1'b1;
        ctrl.alu_op    = ALU_XOR;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.is_branch = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      OP_J:    ctrl.is_jump = 1'b1;
      default: ctrl = ctrl;
    endcase
  end

  // R-type writes rd, everything else writes rt.
  assign dest    = (opcode == OP_RTYPE) ? bus.instruction[15:11] : bus.instruction[20:16];
  assign ext_imm = ctrl.zext ? {{(WIDTH-16){1'b0}}, imm} : {{(WIDTH-16){imm[15]}}, imm};
  assign alu_in2 = ctrl.alu_src ? ext_imm : bus.data_b;

  mips_alu u_alu (
    .in1    (bus.data_a),
    .in2    (alu_in2),
    .op     (ctrl.alu_op),
    .shamt  (bus.instruction[10:6]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.addr_in   <= '0;
      bus.reg_write <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.is_branch <= 1'b0;
      bus.is_jump   <= 1'b0;
      bus.imm16     <= '0;
      bus.addr26    <= '0;
      bus.alu_out   <= '0;
      bus.alu_zout  <= 1'b0;
    end else begin
      bus.addr_in   <= dest;
      bus.reg_write <= ctrl.reg_write;
      bus.mem_write <= ctrl.mem_write;
      bus.is_branch <= ctrl.is_branch;
      bus.is_jump   <= ctrl.is_jump;
      bus.imm16     <= imm;
      bus.addr26    <= bus.instruction[25:0];
      bus.alu_out   <= alu_result;
      bus.alu_zout  <= alu_zero;
    end
  end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Self-checking bench for mips_decode_execute: directed instruction table plus
// random add/sub traffic, checked through an expected-output queue.
module tb_mips_decode_execute;

  localparam int W = 84;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];

  mips_decode_execute_if bus();

  mips_decode_execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Layout: addr_in[83:79] reg_write[78] mem_write[77] is_branch[76] is_jump[75]
  //         imm16[74:59] addr26[58:33] alu_out[32:1] alu_zout[0]
  function automatic logic [W-1:0] pack(input logic [4:0] ai, input logic rw, input logic mw,
                                        input logic br, input logic jp, input logic [15:0] im,
                                        input logic [25:0] a26, input logic [31:0] alu,
                                        input logic z);
    return {ai, rw, mw, br, jp, im, a26, alu, z};
  endfunction

  function automatic logic [W-1:0] observed();
    return pack(bus.addr_in, bus.reg_write, bus.mem_write, bus.is_branch, bus.is_jump,
                bus.imm16, bus.addr26, bus.alu_out, bus.alu_zout);
  endfunction

  task automatic compare_next();
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] o;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    o = observed();
    if (m[83:79] != 0) check("addr_in",   32'(o[83:79]), 32'(e[83:79]));
    check("reg_write", 32'(o[78]), 32'(e[78]));
    check("mem_write", 32'(o[77]), 32'(e[77]));
    check("is_branch", 32'(o[76]), 32'(e[76]));
    check("is_jump",   32'(o[75]), 32'(e[75]));
    check("imm16",     32'(o[74:59]), 32'(e[74:59]));
    check("addr26",    32'(o[58:33]), 32'(e[58:33]));
    if (m[32:1] != 0) check("alu_out",  o[32:1], e[32:1]);
    if (m[0] != 0)    check("alu_zout", 32'(o[0]), 32'(e[0]));
  endtask

  // Drive one instruction, push its expected registered result, compare after the edge.
  task automatic txn(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] ai, input logic rw, input logic mw, input logic br,
                     input logic jp, input logic [31:0] alu, input logic use_ai,
                     input logic use_alu);
    logic [W-1:0] m;
    @(negedge clk);
    bus.instruction = instr;
    bus.data_a      = a;
    bus.data_b      = b;
    #1;
    check("addr_a", 32'(bus.addr_a), 32'(instr[25:21]));
    check("addr_b", 32'(bus.addr_b), 32'(instr[20:16]));
    m = '1;
    if (!use_ai)  m[83:79] = '0;
    if (!use_alu) m[32:0]  = '0;
    exp_q.push_back(pack(ai, rw, mw, br, jp, instr[15:0], instr[25:0], alu, alu == 32'd0));
    msk_q.push_back(m);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  task automatic reset_check(input logic [31:0] instr);
    @(negedge clk);
    rst_n           = 1'b0;
    bus.instruction = instr;
    bus.data_a      = 32'h1111_1111;
    bus.data_b      = 32'h2222_2222;
    exp_q.push_back('0);
    msk_q.push_back('1);
    repeat (2) @(posedge clk);
    #1;
    compare_next();
    check("rst_addr_a", 32'(bus.addr_a), 32'(instr[25:21]));
    check("rst_addr_b", 32'(bus.addr_b), 32'(instr[20:16]));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, r;
    logic        is_sub;
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus.instruction = '0;
    bus.data_a      = '0;
    bus.data_b      = '0;

    reset_check(32'h0022_1820);

    //   instr          data_a         data_b         ai  rw mw br jp alu            ai? alu?
    txn(32'h0022_1820, 32'd5,         32'd7,         3,  1, 0, 0, 0, 32'd12,        1, 1); // add
    txn(32'h0022_1822, 32'h8000_0000, 32'h8000_0000, 3,  1, 0, 0, 0, 32'd0,         1, 1); // sub -> 0
    txn(32'h0022_1822, 32'd0,         32'd1,         3,  1, 0, 0, 0, 32'hFFFF_FFFF, 1, 1); // sub wrap
    txn(32'h2022_FFFF, 32'd1,         32'h5555_5555, 2,  1, 0, 0, 0, 32'd0,         1, 1); // addi -1
    txn(32'h3422_FFFF, 32'd0,         32'h5555_5555, 2,  1, 0, 0, 0, 32'h0000_FFFF, 1, 1); // ori zext
    txn(32'h3022_8000, 32'hFFFF_FFFF, 32'd0,         2,  1, 0, 0, 0, 32'h0000_8000, 1, 1); // andi zext
    txn(32'h3822_FFFF, 32'hFFFF_0000, 32'd0,         2,  1, 0, 0, 0, 32'hFFFF_FFFF, 1, 1); // xori
    txn(32'h2822_FFFF, 32'hFFFF_FFFE, 32'd0,         2,  1, 0, 0, 0, 32'd1,         1, 1); // slti -2<-1
    txn(32'h0022_182A, 32'hFFFF_FFFF, 32'd1,         3,  1, 0, 0, 0, 32'd1,         1, 1); // slt signed
    txn(32'h0022_182A, 32'd1,         32'hFFFF_FFFF, 3,  1, 0, 0, 0, 32'd0,         1, 1); // slt false
    txn(32'h0002_1FC0, 32'h1234_5678, 32'd1,         3,  1, 0, 0, 0, 32'h8000_0000, 1, 1); // sll 31
    txn(32'h0002_1FC2, 32'h1234_5678, 32'h8000_0000, 3,  1, 0, 0, 0, 32'd1,         1, 1); // srl 31
    txn(32'h0002_1800, 32'h0,         32'hDEAD_BEEF, 3,  1, 0, 0, 0, 32'hDEAD_BEEF, 1, 1); // sll 0
    txn(32'h0022_1824, 32'hF0F0_F0F0, 32'hFF00_FF00, 3,  1, 0, 0, 0, 32'hF000_F000, 1, 1); // and
    txn(32'h0022_1825, 32'hF0F0_F0F0, 32'h0F00_0F00, 3,  1, 0, 0, 0, 32'hFFF0_FFF0, 1, 1); // or
    txn(32'h0022_1826, 32'hFFFF_0000, 32'hFF00_FF00, 3,  1, 0, 0, 0, 32'h00FF_FF00, 1, 1); // xor
    txn(32'h1022_0010, 32'h55,        32'h55,        0,  0, 0, 1, 0, 32'd0,         0, 1); // beq taken
    txn(32'h1022_0010, 32'h55,        32'h54,        0,  0, 0, 1, 0, 32'd1,         0, 1); // beq not taken
    txn(32'h0800_0010, 32'h0,         32'h0,         0,  0, 0, 0, 1, 32'd0,         0, 0); // j
    txn(32'hAC22_0004, 32'h100,       32'h9999,      2,  0, 1, 0, 0, 32'h104,       1, 1); // sw
    txn(32'h8C22_FFFC, 32'h100,       32'h9999,      2,  1, 0, 0, 0, 32'hFC,        1, 1); // lw -4
    txn(32'hFC22_1820, 32'd5,         32'd7,         0,  0, 0, 0, 0, 32'd0,         0, 0); // bad opcode
    txn(32'h0022_183F, 32'd5,         32'd7,         0,  0, 0, 0, 0, 32'd0,         0, 0); // bad funct
    txn(32'h0022_0020, 32'd1,         32'd2,         0,  1, 0, 0, 0, 32'd3,         1, 1); // add to $0

    for (int i = 0; i < 24; i++) begin
      rs     = 5'($urandom_range(0, 31));
      rt     = 5'($urandom_range(0, 31));
      rd     = 5'($urandom_range(0, 31));
      a      = $urandom;
      b      = (i % 4 == 0) ? a : $urandom;
      is_sub = 1'($urandom_range(0, 1));
      r      = is_sub ? a - b : a + b;
      txn({6'h00, rs, rt, rd, 5'h00, is_sub ? 6'h22 : 6'h20}, a, b, rd, 1, 0, 0, 0, r, 1, 1);
    end

    reset_check(32'h0800_0010);
    txn(32'h0022_1820, 32'd5, 32'd7, 3, 1, 0, 0, 0, 32'd12, 1, 1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_decode_execute.md
Name: mips_decode_execute

Overview:
- Single-cycle MIPS decode and execute slice: decodes a 32-bit instruction, drives register-file read addresses, selects the second ALU operand, and runs the 32-bit ALU.
- Decoded controls and ALU results are captured in one output register stage, so the register file, IFU and memory see stable values for one cycle.
- Sits between the IFU/register file and the write-back/IFU branch logic of the processor.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instruction  in  32  current instruction word.
- data_a  in  32  register-file read data for addr_a (rs).
- data_b  in  32  register-file read data for addr_b (rt).
- addr_a  out  5  rs field, instr[25:21]. Combinational.
- addr_b  out  5  rt field, instr[20:16]. Combinational.
- addr_in  out  5  write register: rd for R-type, rt for I-type. Registered.
- reg_write  out  1  write-back enable. Registered.
- mem_write  out  1  store enable. Registered.
- is_branch  out  1  branch instruction. Registered.
- is_jump  out  1  jump instruction. Registered.
- imm16  out  16  instr[15:0]. Registered.
- addr26  out  26  instr[25:0]. Registered.
- alu_out  out  32  ALU result. Registered.
- alu_zout  out  1  1 when the ALU result is 0. Registered.

Behaviour:
- Reset: when rst_n is 0 at a clk rising edge, every registered output is cleared to 0. addr_a and addr_b always follow the instruction, including during reset.
- Latency: registered outputs reflect the instruction, data_a and data_b sampled at the previous rising edge. No handshake; a new instruction is accepted every cycle.
- Operand selection:
  - alu_in1 = data_a.
  - alu_in2 = data_b when alu_src is 0; otherwise the extended imm16.
  - Extension is zero-extend for andi/ori/xori and sign-extend for all other immediates.
- ALU op encoding (3 bits): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
  - ADD and SUB wrap modulo 2^32; there is no overflow trap.
  - SLT is a signed compare and returns 1 or 0.
  - SLL and SRL shift alu_in2 (rt) by shamt = instr[10:6]; SRL is logical.
  - alu_zout is 1 exactly when the 32-bit result is 0.
- Decode for R-type (opcode 0x00), selected by funct:
  - 0x20 and 0x21 ADD; 0x22 and 0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x2A SLT; 0x00 SLL; 0x02 SRL.
  - Controls: reg_write=1, alu_src=0, addr_in=rd.
  - Unknown funct: treated as a NOP with all enables 0.
- Decode for I-type (alu_src=1, addr_in=rt):
  - 0x08 and 0x09 ADD with reg_write.
  - 0x0C AND, 0x0D OR, 0x0E XOR, 0x0A SLT, all with reg_write.
  - 0x23 lw: ADD (address calculation) with reg_write.
  - 0x2B sw: ADD with mem_write.
- Branch: 0x04 beq uses SUB with alu_src=0 and is_branch=1; alu_zout gives the condition.
- Jump: 0x02 j sets is_jump=1 with all other enables 0.
- Unknown opcode: NOP, with reg_write, mem_write, is_branch and is_jump all 0. alu_out still holds the computed ADD result.
- Writes to register 0: reg_write is not suppressed when addr_in is 0; the register file discards such writes.
- SLL with shamt 0 passes rt through unchanged.

Decomposition:
- Package mips_pkg holds:
  - the opcode and funct constants;
  - the alu_op_t 3-bit enum;
  - a ctrl_t struct (reg_write, mem_write, alu_src, is_branch, is_jump, zext, alu_op).
- Sub-module mips_alu holds the pure combinational ALU, with inputs in1, in2, op and shamt and outputs result and zero.
- Decode and the output register stage stay in the top module.

Test Plan:
- Hold rst_n=0 for 2 cycles with a nonzero instruction -> all registered outputs 0; addr_a and addr_b still track instr[25:21] and instr[20:16].
- add $3,$1,$2 (0x00221820), data_a=5, data_b=7 -> next cycle alu_out=12, reg_write=1, addr_in=3, alu_zout=0.
- sub with data_a=data_b=0x8000_0000 -> alu_out=0, alu_zout=1. Then 0x0000_0000 minus 1 -> alu_out=0xFFFF_FFFF, wrapping without a trap.
- addi with imm16=0xFFFF and data_a=1 -> alu_out=0. ori with imm16=0xFFFF and data_a=0 -> alu_out=0x0000_FFFF.
- slt with data_a=0xFFFF_FFFF (-1) and data_b=1 -> alu_out=1. sll with rt=1 and shamt=31 -> alu_out=0x8000_0000. srl of 0x8000_0000 by 31 -> 1.
- beq with equal registers -> is_branch=1, alu_zout=1, reg_write=0. j 0x0000010 -> is_jump=1, addr26=0x0000010. sw -> mem_write=1, reg_write=0. Unknown opcode 0x3F -> all enables 0.
